// File: rtl/cpu_fetch_queue.sv
// Instruction fetch stage: PC generator, pipelined memory requests with in-order
// responses, and a prefetch queue that feeds decode over a valid/ready handshake.
module cpu_fetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_inc,
  output logic               halted
);
  localparam int                PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CW      = PW + 1;
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [CW:0]       DEPTH_O = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      discard_q, discard_d;
  logic               halted_q, halted_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [INSTR_W-1:0] q_instr_q [DEPTH];
  logic [INSTR_W-1:0] q_instr_d [DEPTH];
  logic [ADDR_W-1:0]  q_pc_q    [DEPTH];
  logic [ADDR_W-1:0]  q_pc_d    [DEPTH];
  logic [ADDR_W-1:0]  tag_q     [DEPTH];
  logic [ADDR_W-1:0]  tag_d     [DEPTH];
  logic [INSTR_W-1:0] last_instr_q, last_instr_d;
  logic [ADDR_W-1:0]  last_pc_q, last_pc_d;
  logic [ADDR_W-1:0]  last_pc_inc_q, last_pc_inc_d;

  logic [CW:0]        occupancy;
  logic               issue, enq, deq, is_halt;
  logic [ADDR_W-1:0]  head_pc;

  // Queued entries plus outstanding requests never exceed DEPTH, so every
  // response that is accepted has a free slot waiting for it.
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue     = !rst && !redirect && !halted_q && (occupancy < DEPTH_O);
  assign enq       = mem_rvalid && !redirect && (discard_q == '0);
  assign out_valid = (count_q != '0);
  assign deq       = out_valid && out_ready;
  assign head_pc   = q_pc_q[rd_ptr_q];
  assign is_halt   = (mem_rdata[INSTR_W-1 -: 4] == HALT_OP);

  assign mem_req    = issue;
  assign mem_addr   = fetch_pc_q;
  assign halted     = halted_q;
  assign out_instr  = out_valid ? q_instr_q[rd_ptr_q] : last_instr_q;
  assign out_pc     = out_valid ? head_pc : last_pc_q;
  assign out_pc_inc = out_valid ? head_pc + STEP : last_pc_inc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q + CW'(enq) - CW'(deq);
    inflight_d    = inflight_q + CW'(issue) - CW'(mem_rvalid);
    discard_d     = discard_q;
    halted_d      = halted_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    q_instr_d     = q_instr_q;
    q_pc_d        = q_pc_q;
    tag_d         = tag_q;
    last_instr_d  = last_instr_q;
    last_pc_d     = last_pc_q;
    last_pc_inc_d = last_pc_inc_q;

    if (issue) begin
      tag_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d        = tag_wr_q + PW'(1);
      fetch_pc_d      = fetch_pc_q + STEP;
    end
    // Tags pop on every response, stale or not, so they stay aligned with memory.
    if (mem_rvalid) begin
      tag_rd_d = tag_rd_q + PW'(1);
      if (discard_q != '0) discard_d = discard_q - CW'(1);
    end
    if (enq) begin
      q_instr_d[wr_ptr_q] = mem_rdata;
      q_pc_d[wr_ptr_q]    = tag_q[tag_rd_q];
      wr_ptr_d            = wr_ptr_q + PW'(1);
      if (is_halt) halted_d = 1'b1;
    end
    if (deq) begin
      rd_ptr_d      = rd_ptr_q + PW'(1);
      last_instr_d  = q_instr_q[rd_ptr_q];
      last_pc_d     = head_pc;
      last_pc_inc_d = head_pc + STEP;
    end
    // A handshake in the redirect cycle still completes; the flush applies after it.
    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      discard_d  = inflight_q - CW'(mem_rvalid);
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      inflight_q    <= '0;
      discard_q     <= '0;
      halted_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      last_instr_q  <= '0;
      last_pc_q     <= '0;
      last_pc_inc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      discard_q     <= discard_d;
      halted_q      <= halted_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      last_instr_q  <= last_instr_d;
      last_pc_q     <= last_pc_d;
      last_pc_inc_q <= last_pc_inc_d;
    end
  end

  // Storage is only read behind valid pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    q_instr_q <= q_instr_d;
    q_pc_q    <= q_pc_d;
    tag_q     <= tag_d;
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(enq && !deq && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Randomized bench for cpu_fetch_queue: an in-order variable-latency memory model,
// an epoch-based reference of which fetches must reach decode, and a scoreboard.
module tb_cpu_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, mem_rvalid = 1'b0, redirect = 1'b0, out_ready = 1'b0;
  logic        mem_req, out_valid, halted;
  logic [15:0] mem_addr, out_instr, out_pc, out_pc_inc;
  logic [15:0] mem_rdata = 16'h0, redirect_pc = 16'h0;

  always #5 clk = ~clk;

  cpu_fetch_queue #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH), .PC_STEP(2),
    .RESET_PC(16'h0000), .HALT_OP(4'hF)
  ) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_inc(out_pc_inc), .halted(halted)
  );

  typedef struct packed { logic [15:0] addr; logic [15:0] data; int epoch; int ready; } req_t;
  typedef struct packed { logic [15:0] pc; logic [15:0] instr; } exp_t;

  req_t        pend[$];
  exp_t        exp_q[$];
  int          checks = 0, failures = 0, cyc = 0, epoch = 0, last_ready = 0;
  int          deliveries = 0, exp_size_snap = 0;
  int          lat_min = 1, lat_max = 1;
  logic        halt_en = 1'b0, halted_m = 1'b0, exp_req;
  logic [15:0] halt_addr = 16'h0, next_pc = 16'h0;
  logic [15:0] last_pc = 16'h0, last_instr = 16'h0, last_inc = 16'h0, inc;
  req_t        r;
  exp_t        e;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hF000;
    return a & 16'h7FFF;
  endfunction

  // Monitor: compares what decode sees against the scoreboard head.
  always @(negedge clk) begin
    exp_size_snap = exp_q.size();
    if (rst) begin
      exp_q.delete();
      last_pc = 16'h0; last_instr = 16'h0; last_inc = 16'h0;
    end else begin
      check("out_valid", 16'(out_valid), 16'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        e   = exp_q[0];
        inc = e.pc + 16'd2;
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
        check("out_pc_inc", out_pc_inc, inc);
        if (out_ready) begin
          $display("xfer cycle=%0d pc=%h instr=%h", cyc, out_pc, out_instr);
          last_pc = e.pc; last_instr = e.instr; last_inc = inc;
          void'(exp_q.pop_front());
          deliveries++;
        end
      end else if (!out_valid && exp_q.size() == 0) begin
        check("hold_pc", out_pc, last_pc);
        check("hold_instr", out_instr, last_instr);
        check("hold_pc_inc", out_pc_inc, last_inc);
      end
      if (redirect) exp_q.delete();
    end
  end

  // Reference model: request stream, memory latency, stale-epoch drop and halt.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      check("mem_req_rst", 16'(mem_req), 16'h0);
      pend.delete();
      next_pc = 16'h0000; halted_m = 1'b0; last_ready = 0;
    end else begin
      exp_req = !redirect && !halted_m && (exp_size_snap + pend.size() < DEPTH);
      check("mem_req", 16'(mem_req), 16'(exp_req));
      check("halted", 16'(halted), 16'(halted_m));
      if (mem_rvalid) begin
        if (pend.size() == 0) begin
          check("rvalid_without_request", 16'h1, 16'h0);
        end else begin
          r = pend.pop_front();
          if (!redirect && r.epoch == epoch) begin
            e.pc = r.addr; e.instr = r.data;
            exp_q.push_back(e);
            if (r.data[15:12] == 4'hF) halted_m = 1'b1;
          end
        end
      end
      if (mem_req) begin
        check("mem_addr", mem_addr, next_pc);
        r.addr  = next_pc;
        r.data  = mem_data(next_pc);
        r.epoch = epoch;
        r.ready = cyc + int'($urandom_range(lat_max, lat_min));
        if (r.ready <= last_ready) r.ready = last_ready + 1;
        last_ready = r.ready;
        pend.push_back(r);
        next_pc = next_pc + 16'd2;
      end
      if (redirect) begin
        epoch++;
        next_pc  = redirect_pc;
        halted_m = 1'b0;
      end
    end
  end

  task automatic step(input logic r_rst, input logic r_redir, input logic [15:0] r_pc,
                      input logic r_ready);
    @(posedge clk);
    #1;
    cyc++;
    rst = r_rst; redirect = r_redir; redirect_pc = r_pc; out_ready = r_ready;
    if (!r_rst && pend.size() > 0 && pend[0].ready <= cyc) begin
      mem_rvalid = 1'b1; mem_rdata = pend[0].data;
    end else begin
      mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
    end
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, rdy);
  endtask

  initial begin
    logic [15:0] rpc;
    // Reset, single-cycle memory, decode always ready
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    run(20, 1'b1);
    // Decode stall fills the queue, then drains in order
    run(12, 1'b0);
    run(20, 1'b1);
    // Redirect with three requests in flight
    lat_min = 3; lat_max = 3;
    run(6, 1'b1);
    step(1'b0, 1'b1, 16'h0100, 1'b1);
    run(20, 1'b1);
    // Halt instruction at 0x0006 stops fetch; redirect resumes
    lat_min = 1; lat_max = 1;
    halt_en = 1'b1; halt_addr = 16'h0006;
    step(1'b1, 1'b0, 16'h0, 1'b1);
    run(15, 1'b1);
    #1;
    check("halt_stop", 16'(halted), 16'h1);
    check("halt_noreq", 16'(mem_req), 16'h0);
    halt_en = 1'b0;
    step(1'b0, 1'b1, 16'h0020, 1'b1);
    run(10, 1'b1);
    #1;
    check("halt_release", 16'(halted), 16'h0);
    // Address wrap at the top of the space
    step(1'b0, 1'b1, 16'hFFFC, 1'b1);
    run(10, 1'b1);
    // Reset with requests in flight and entries queued
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b1, 16'h0040, 1'b0);
    run(6, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    #1;
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_halted", 16'(halted), 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    run(10, 1'b1);
    // Randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(999, 0) < 5) begin
        step(1'b1, 1'b0, 16'h0, 1'b1);
      end else if ($urandom_range(99, 0) < 3) begin
        rpc       = 16'($urandom) & 16'hFFFE;
        halt_en   = ($urandom_range(1, 0) == 1);
        halt_addr = rpc + 16'(2 * $urandom_range(8, 0));
        step(1'b0, 1'b1, rpc, ($urandom_range(99, 0) < 70));
      end else begin
        step(1'b0, 1'b0, 16'h0, ($urandom_range(99, 0) < 70));
      end
    end
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("deliveries", 16'(deliveries > 200), 16'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
